mul_seq: RTL

- Multi-cycle multiply sequencer for the ARM execute stage.
- Executes MUL, MLA, UMULL, SMULL, UMLAL and SMLAL as a radix-2 shift-add iteration over a 64-bit accumulator. Produces the result and updated NZCV flags.
- Sits beside the single-cycle ALU. The decode/issue logic stalls the pipeline on busy and writes back on done.

---
 rtl/mul_seq_if.sv | 37 +++
 rtl/mul_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mul_seq_if.sv
// Issue/result bundle between the execute-stage decode logic (master) and the
// shift-add multiply sequencer (slave).
interface mul_seq_if;
    logic        start;
    logic        op_long;
    logic        op_signed;
    logic        op_acc;
    logic        s_bit;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        out_n;
    logic        out_z;
    logic        out_c;
    logic        out_v;

    modport master (
        output start, op_long, op_signed, op_acc, s_bit,
        output rm, rs, acc_lo, acc_hi, n, z, c, v,
        input  busy, done, res_lo, res_hi, out_n, out_z, out_c, out_v
    );

    modport slave (
        input  start, op_long, op_signed, op_acc, s_bit,
        input  rm, rs, acc_lo, acc_hi, n, z, c, v,
        output busy, done, res_lo, res_hi, out_n, out_z, out_c, out_v
    );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiply sequencer for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.
// Optional macro MUL_EARLY_TERM_EN: finish after 8/16/24 steps once the multiplier is exhausted.
module mul_seq #(
    parameter int ITER_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    mul_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       p_q, p_d;
    logic [63:0]       mc_q, mc_d;
    logic [31:0]       mr_q, mr_d;
    logic [ITER_W-1:0] i_q, i_d;
    logic              long_q, long_d;
    logic              sgn_q, sgn_d;
    logic              s_bit_q, s_bit_d;
    logic [3:0]        nzcv_in_q, nzcv_in_d;
    logic [31:0]       res_lo_q, res_lo_d;
    logic [31:0]       res_hi_q, res_hi_d;
    logic [3:0]        nzcv_out_q, nzcv_out_d;

    logic [63:0]       addend;
    logic [63:0]       p_step;
    logic              last_step;
    logic              early_stop;
    logic              accept;
    logic              flag_n;
    logic              flag_z;

    // The signed-long correction: bit 31 of the multiplier carries weight -2^31.
    always_comb begin
        addend    = mr_q[0] ? (mc_q << i_q) : 64'd0;
        p_step    = (sgn_q && (i_q == ITER_W'(31))) ? (p_q - addend) : (p_q + addend);
        last_step = (i_q == ITER_W'(31));
    end

`ifdef MUL_EARLY_TERM_EN
    always_comb begin
        early_stop = ((i_q + ITER_W'(1)) == ITER_W'(8)  ||
                      (i_q + ITER_W'(1)) == ITER_W'(16) ||
                      (i_q + ITER_W'(1)) == ITER_W'(24)) &&
                     ((mr_q >> 1) == 32'd0);
    end
`else
    always_comb begin
        early_stop = 1'b0;
    end
`endif

    always_comb begin
        flag_n = long_q ? p_step[63] : p_step[31];
        flag_z = long_q ? (p_step == 64'd0) : (p_step[31:0] == 32'd0);
    end

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        mc_d       = mc_q;
        mr_d       = mr_q;
        i_d        = i_q;
        long_d     = long_q;
        sgn_d      = sgn_q;
        s_bit_d    = s_bit_q;
        nzcv_in_d  = nzcv_in_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        nzcv_out_d = nzcv_out_q;
        accept     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    accept = 1'b1;
                end
            end
            S_ITER: begin
                p_d  = p_step;
                mr_d = mr_q >> 1;
                i_d  = i_q + ITER_W'(1);
                if (last_step || early_stop) begin
                    state_d    = S_DONE;
                    res_lo_d   = p_step[31:0];
                    res_hi_d   = long_q ? p_step[63:32] : 32'd0;
                    nzcv_out_d = s_bit_q ? {flag_n, flag_z, nzcv_in_q[1:0]} : nzcv_in_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d   = S_ITER;
            p_d       = bus.op_acc ? {(bus.op_long ? bus.acc_hi : 32'd0), bus.acc_lo} : 64'd0;
            mc_d      = (bus.op_long && bus.op_signed) ? {{32{bus.rm[31]}}, bus.rm}
                                                       : {32'd0, bus.rm};
            mr_d      = bus.rs;
            i_d       = '0;
            long_d    = bus.op_long;
            sgn_d     = bus.op_long && bus.op_signed;
            s_bit_d   = bus.s_bit;
            nzcv_in_d = {bus.n, bus.z, bus.c, bus.v};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p_q        <= 64'd0;
            mc_q       <= 64'd0;
            mr_q       <= 32'd0;
            i_q        <= '0;
            long_q     <= 1'b0;
            sgn_q      <= 1'b0;
            s_bit_q    <= 1'b0;
            nzcv_in_q  <= 4'd0;
            res_lo_q   <= 32'd0;
            res_hi_q   <= 32'd0;
            nzcv_out_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            mc_q       <= mc_d;
            mr_q       <= mr_d;
            i_q        <= i_d;
            long_q     <= long_d;
            sgn_q      <= sgn_d;
            s_bit_q    <= s_bit_d;
            nzcv_in_q  <= nzcv_in_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            nzcv_out_q <= nzcv_out_d;
        end
    end

    assign bus.busy   = (state_q == S_ITER);
    assign bus.done   = (state_q == S_DONE);
    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.out_n  = nzcv_out_q[3];
    assign bus.out_z  = nzcv_out_q[2];
    assign bus.out_c  = nzcv_out_q[1];
    assign bus.out_v  = nzcv_out_q[0];

endmodule
